// File: rtl/regm_pkg.sv
// Shared defaults, FSM encoding and constants for the multi-port register memory.
package regm_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 4;
  localparam int DEF_NWRITE = 2;

  localparam int ZERO_REG = 0;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/regm_mp_bypass.sv
// One read port: forwards same-cycle write data (highest write port wins) and
// masks the busy bit of a register whose result completes this cycle.
module regm_mp_bypass
  import regm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NWRITE = DEF_NWRITE
) (
  input  logic                     run,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr,
  input  logic [NWRITE*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]        stored,
  input  logic                     busy,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  logic hit;

  always_comb begin
    rd_data = stored;
    hit     = 1'b0;
    // Ascending scan so the youngest matching write port overrides older ones.
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
        rd_data = wr_data[j*DATA_W +: DATA_W];
        hit     = 1'b1;
      end
    end
    rd_busy = busy & ~hit;
    if (!run || (rd_addr == ADDR_W'(ZERO_REG))) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regm_mp.sv
// Parametrised multi-port register file with post-reset zeroing sweep,
// per-register busy scoreboard and ordered write-port priority.
module regm_mp
  import regm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD,
  parameter int NWRITE = DEF_NWRITE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr,
  input  logic [NWRITE*DATA_W-1:0] wr_data,
  input  logic [NWRITE-1:0]        rsv_en,
  input  logic [NWRITE*ADDR_W-1:0] rsv_addr,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_e              state;
  logic [ADDR_W:0]     cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    busy_nxt;
  logic                run;

  assign run   = (state == ST_RUN);
  assign ready = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= ST_RUN;
    end
  end

  // Storage carries no reset; the sweep zeroes it. Later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)))
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Clears applied before sets so a same-cycle reservation of a younger instruction wins.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j]) busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    for (int j = 0; j < NWRITE; j++) begin
      if (rsv_en[j]) busy_nxt[rsv_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   busy <= '0;
    else if (run) busy <= busy_nxt;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regm_mp_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWRITE (NWRITE)
    ) u_bypass (
      .run     (run),
      .rd_addr (addr),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .stored  (mem[addr]),
      .busy    (busy[addr]),
      .rd_data (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regm_mp.sv
// Directed self-checking bench for regm_mp at default parameters (32x32, 4R/2W).
module tb_regm_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NR*AW-1:0]   rd_addr = '0;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_busy;
  logic [NW-1:0]      wr_en = '0;
  logic [NW*AW-1:0]   wr_addr = '0;
  logic [NW*DW-1:0]   wr_data = '0;
  logic [NW-1:0]      rsv_en = '0;
  logic [NW*AW-1:0]   rsv_addr = '0;
  logic               ready;

  int tests = 0;
  int fails = 0;

  regm_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    rsv_en = '0;
  endtask

  task automatic set_rd_all(input logic [AW-1:0] a);
    for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = a;
  endtask

  task automatic drive_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic drive_rsv(input int p, input logic [AW-1:0] a);
    rsv_en[p]            = 1'b1;
    rsv_addr[p*AW +: AW] = a;
  endtask

  task automatic chk_data(input string name, input int port, input logic [DW-1:0] exp);
    logic [DW-1:0] got;
    got = rd_data[port*DW +: DW];
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s port%0d: rd_data=%h expected %h", name, port, got, exp);
    end
  endtask

  task automatic chk_busy(input string name, input int port, input logic exp);
    tests++;
    if (rd_busy[port] !== exp) begin
      fails++;
      $display("FAIL %s port%0d: rd_busy=%b expected %b", name, port, rd_busy[port], exp);
    end
  endtask

  task automatic chk_ready(input string name, input logic exp);
    tests++;
    if (ready !== exp) begin
      fails++;
      $display("FAIL %s: ready=%b expected %b", name, ready, exp);
    end
  endtask

  // After release: ready low for 32 cycles while writes/reservations to r5 are driven,
  // then high on cycle 33 with r5 still zero and not busy.
  task automatic sweep_after_release(input string name);
    set_rd_all(5'd5);
    drive_wr(0, 5'd5, 32'hDEAD_BEEF);
    drive_rsv(1, 5'd5);
    rst_n = 1'b1;
    #1;
    for (int c = 1; c <= 32; c++) begin
      chk_ready(name, 1'b0);
      chk_data(name, 0, 32'h0);
      chk_busy(name, 1, 1'b0);
      step();
    end
    idle();
    #1;
    chk_ready(name, 1'b1);
    chk_data(name, 2, 32'h0);
    chk_busy(name, 3, 1'b0);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    set_rd_all(5'd5);
    step();
    step();
    chk_ready("reset_ready", 1'b0);
    chk_data("reset_data", 0, 32'h0);
    chk_busy("reset_busy", 0, 1'b0);
  endtask

  task automatic test_sweep();
    sweep_after_release("sweep");
  endtask

  task automatic test_reset_mid_sweep();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) step();
    rst_n = 1'b0;
    #1;
    chk_ready("midsweep_in_reset", 1'b0);
    step();
    step();
    sweep_after_release("midsweep");
  endtask

  task automatic test_write_conflict();
    idle();
    set_rd_all(5'd7);
    #1;
    chk_data("conflict_pre", 0, 32'h0);
    drive_wr(0, 5'd7, 32'hAAAA_0000);
    drive_wr(1, 5'd7, 32'h5555_FFFF);
    #1;
    chk_data("conflict_fwd", 0, 32'h5555_FFFF);
    chk_data("conflict_fwd", 3, 32'h5555_FFFF);
    step();
    idle();
    #1;
    chk_data("conflict_store", 0, 32'h5555_FFFF);
    chk_data("conflict_store", 2, 32'h5555_FFFF);
  endtask

  task automatic test_bypass();
    idle();
    set_rd_all(5'd3);
    drive_wr(0, 5'd3, 32'h1234_5678);
    drive_wr(1, 5'd4, 32'hCAFE_F00D);
    #1;
    for (int i = 0; i < NR; i++) chk_data("bypass_p0", i, 32'h1234_5678);
    step();
    idle();
    rd_addr[AW +: AW] = 5'd4;
    #1;
    chk_data("bypass_store_r3", 0, 32'h1234_5678);
    chk_data("bypass_store_r4", 1, 32'hCAFE_F00D);
    // Port 1 alone forwarding to a read port.
    drive_wr(1, 5'd3, 32'h0BAD_CAFE);
    #1;
    chk_data("bypass_p1", 2, 32'h0BAD_CAFE);
    chk_data("bypass_other", 1, 32'hCAFE_F00D);
    step();
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd_all(5'd9);
    drive_rsv(0, 5'd9);
    #1;
    chk_busy("rsv_same_cycle", 0, 1'b0);
    step();
    idle();
    #1;
    chk_busy("rsv_t1", 0, 1'b1);
    chk_busy("rsv_t1", 3, 1'b1);
    step();
    #1;
    chk_busy("rsv_t2", 1, 1'b1);
    step();
    drive_wr(0, 5'd9, 32'h0000_0099);
    #1;
    chk_busy("wr_t3", 0, 1'b0);
    chk_data("wr_t3_fwd", 0, 32'h0000_0099);
    step();
    idle();
    #1;
    chk_busy("wr_t4", 2, 1'b0);
    // Write and reservation to r9 in the same cycle: reservation wins.
    drive_rsv(1, 5'd9);
    drive_wr(0, 5'd9, 32'h0000_0123);
    #1;
    chk_busy("set_clr_same", 0, 1'b0);
    step();
    idle();
    #1;
    chk_busy("set_clr_next", 0, 1'b1);
    // Already busy with set+clear again: still busy afterwards.
    drive_rsv(1, 5'd9);
    drive_wr(1, 5'd9, 32'h0000_0456);
    #1;
    chk_busy("busy_set_clr_same", 1, 1'b0);
    step();
    idle();
    #1;
    chk_busy("busy_set_clr_next", 1, 1'b1);
    chk_data("busy_set_clr_data", 1, 32'h0000_0456);
    drive_wr(1, 5'd9, 32'h0000_0789);
    step();
    idle();
    #1;
    chk_busy("final_clear", 3, 1'b0);
  endtask

  task automatic test_zero_reg();
    idle();
    set_rd_all(5'd0);
    drive_wr(0, 5'd0, 32'hFFFF_FFFF);
    drive_wr(1, 5'd0, 32'hFFFF_FFFF);
    drive_rsv(0, 5'd0);
    drive_rsv(1, 5'd0);
    #1;
    for (int i = 0; i < NR; i++) begin
      chk_data("zero_same", i, 32'h0);
      chk_busy("zero_same", i, 1'b0);
    end
    step();
    idle();
    #1;
    for (int i = 0; i < NR; i++) begin
      chk_data("zero_after", i, 32'h0);
      chk_busy("zero_after", i, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_reset_mid_sweep();
    test_write_conflict();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
